// File: rtl/mult_div_unit_if.sv
// HI/LO multiply/divide unit request/response bundle.
// master drives start/op/a/b; slave returns busy/hi/lo.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO mult/div unit (EX stage); clk, reset, md slave port.
// Ports: md.start/op/a/b in, md.busy/hi/lo out. Option: MD_MADD_EN.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        busy_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  logic fin;
  logic take;
  logic arith;
  logic is_div;

  assign fin  = (state == BUSY) && (cnt == 4'd1);
  assign take = md.start && ((state == IDLE) || fin);

  always_comb begin
    arith  = 1'b0;
    is_div = 1'b0;
    unique case (1'b1)
      (md.op == OP_MULT),
      (md.op == OP_MULTU): arith = 1'b1;
      (md.op == OP_DIV),
      (md.op == OP_DIVU): begin
        arith  = 1'b1;
        is_div = 1'b1;
      end
`ifdef MD_MADD_EN
      (md.op == OP_MADD),
      (md.op == OP_MSUB): arith = 1'b1;
`endif
      default: ;
    endcase
  end

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a_q[31]}}, a_q}
                * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes through the
  // one unsigned divider; min/-1 wraps naturally.
  logic        sgn;
  logic        b_zero;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  assign sgn    = (op_q == OP_DIV);
  assign b_zero = (b_q == 32'd0);
  assign dvd = (sgn && a_q[31]) ? -a_q : a_q;
  assign dvs = b_zero ? 32'd1
             : (sgn && b_q[31]) ? -b_q : b_q;
  assign uq  = dvd / dvs;
  assign ur  = dvd % dvs;
  assign q   = (sgn && (a_q[31] ^ b_q[31]))
             ? -uq : uq;
  assign r   = (sgn && a_q[31]) ? -ur : ur;

  logic        res_wr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    res_wr = 1'b1;
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV,
      OP_DIVU: begin
        if (b_zero) begin
          res_wr = 1'b0;
        end else begin
          res_lo = q;
          res_hi = r;
        end
      end
`ifdef MD_MADD_EN
      OP_MADD:
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OP_MSUB:
        {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
`endif
      default: res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      if (fin) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        cnt    <= 4'd0;
        if (res_wr) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      // A new op may land on the completion edge;
      // its MTHI/MTLO write wins over the result.
      if (take) begin
        if (arith) begin
          state  <= BUSY;
          busy_q <= 1'b1;
          op_q   <= md.op;
          a_q    <= md.a;
          b_q    <= md.b;
          cnt    <= is_div ? 4'(DIV_CYCLES)
                           : 4'(MULT_CYCLES);
        end else if (md.op == OP_MTHI) begin
          hi_q <= md.a;
        end else if (md.op == OP_MTLO) begin
          lo_q <= md.a;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Define MD_MADD_EN for both files to cover MADD/MSUB.
module tb_mult_div_unit;

  localparam logic [2:0] MULT  = 3'd0;
  localparam logic [2:0] MULTU = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] DIVU  = 3'd3;
  localparam logic [2:0] MTHI  = 3'd4;
  localparam logic [2:0] MTLO  = 3'd5;
  localparam logic [2:0] MADD  = 3'd6;
  localparam logic [2:0] MSUB  = 3'd7;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   n;

  mult_div_unit_if md ();

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic issue(
    input logic [2:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    @(negedge clk);
    md.start = 1'b1;
    md.op    = o;
    md.a     = x;
    md.b     = y;
    @(posedge clk);
    #1 md.start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (md.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run(
    input string       tag,
    input logic [2:0]  o,
    input logic [31:0] x,
    input logic [31:0] y,
    input int          cyc,
    input logic [31:0] ehi,
    input logic [31:0] elo
  );
    int c;
    issue(o, x, y);
    wait_done(c);
    chk({tag, "_cyc"}, c, cyc);
    chk({tag, "_hi"}, md.hi, ehi);
    chk({tag, "_lo"}, md.lo, elo);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    reset    = 1'b1;
    md.start = 1'b0;
    md.op    = 3'd0;
    md.a     = 32'd0;
    md.b     = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);
    reset = 1'b0;

    run("mult", MULT, 32'hFFFFFFFE, 32'd3, 5,
        32'hFFFFFFFF, 32'hFFFFFFFA);
    run("multu", MULTU, 32'hFFFFFFFF,
        32'hFFFFFFFF, 5,
        32'hFFFFFFFE, 32'h00000001);
    run("div", DIV, 32'hFFFFFFF9, 32'd2, 10,
        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu0", DIVU, 32'd7, 32'd0, 10,
        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divmin", DIV, 32'h80000000,
        32'hFFFFFFFF, 10,
        32'h00000000, 32'h80000000);
    run("divneg", DIV, 32'd7, 32'hFFFFFFFE, 10,
        32'h00000001, 32'hFFFFFFFD);

    issue(MTHI, 32'h1234, 32'd0);
    issue(MTLO, 32'h5678, 32'd0);
    @(negedge clk);
    chk("mt_busy", {31'd0, md.busy}, 32'd0);
    chk("mt_hi", md.hi, 32'h1234);
    chk("mt_lo", md.lo, 32'h5678);

    issue(MULT, 32'd3, 32'd4);
    fork
      wait_done(n);
      begin
        @(negedge clk);
        chk("hold_hi", md.hi, 32'h1234);
        chk("hold_lo", md.lo, 32'h5678);
        md.start = 1'b1;
        md.op    = MULT;
        md.a     = 32'd9;
        md.b     = 32'd9;
        @(negedge clk);
        md.op    = MTHI;
        md.a     = 32'hDEAD;
        @(negedge clk);
        md.start = 1'b0;
        md.a     = 32'h77;
        md.b     = 32'h77;
      end
    join
    chk("ign_cyc", n, 5);
    chk("ign_hi", md.hi, 32'd0);
    chk("ign_lo", md.lo, 32'd12);

    issue(MULTU, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    issue(DIVU, 32'd100, 32'd7);
    @(negedge clk);
    chk("b2b_busy", {31'd0, md.busy}, 32'd1);
    chk("b2b_lo1", md.lo, 32'd6);
    wait_done(n);
    chk("b2b_cyc", n, 9);
    chk("b2b_hi", md.hi, 32'd2);
    chk("b2b_lo", md.lo, 32'd14);

    issue(DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, md.busy}, 32'd0);
    chk("mrst_hi", md.hi, 32'd0);
    chk("mrst_lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run("postrst", DIV, 32'd7, 32'hFFFFFFFE, 10,
        32'h00000001, 32'hFFFFFFFD);

`ifdef MD_MADD_EN
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'd10, 32'd0);
    run("madd", MADD, 32'd2, 32'd3, 5,
        32'd0, 32'd16);
    run("msub", MSUB, 32'd1, 32'd17, 5,
        32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    issue(MADD, 32'd5, 32'd5);
    @(negedge clk);
    chk("nop6_busy", {31'd0, md.busy}, 32'd0);
    @(negedge clk);
    chk("nop6_busy2", {31'd0, md.busy}, 32'd0);
    chk("nop6_hi", md.hi, 32'h00000001);
    chk("nop6_lo", md.lo, 32'hFFFFFFFD);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
